// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the programmable clock divider.
//   MIN_DIV      smallest divide ratio a channel will run at
//   DEFAULT_DIV  ratio loaded at reset (100 MHz -> 10 MHz)
//   ch_idx_w()   width of a channel-index field for n channels
package clkdiv_pkg;

    localparam int MIN_DIV     = 2;
    localparam int DEFAULT_DIV = 10;

    // Channel index width; never below one bit so a port can always exist.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: period counter, shadow/active ratio pair and
// registered div_clk / tick outputs.
//   clk_i      system clock
//   reset_i    synchronous active-high reset
//   en_i       run enable; low holds the counter at 0 and outputs low
//   sync_i     restart the period at cnt = 0 and apply any pending ratio
//   wr_i       accepted config write for this channel
//   wr_div_i   requested ratio (0/1 clamp to MIN_DIV)
//   div_clk_o  divided clock, high for ceil(N/2) of every N cycles
//   tick_o     one-cycle pulse on the last cycle of each period
//   pending_o  shadow ratio waiting for the next period boundary
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = clkdiv_pkg::DEFAULT_DIV
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic [DIV_W-1:0] wr_div_i,
    output logic             div_clk_o,
    output logic             tick_o,
    output logic             pending_o
);

    localparam logic [DIV_W-1:0] DEF_N = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] MIN_N = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
    localparam logic [DIV_W:0]   ONE_W = (DIV_W+1)'(1);

    // Ratios below the minimum would leave no low phase; force them up.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < MIN_N) ? MIN_N : d;
    endfunction

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] active_q, active_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             run_q;
    logic             div_clk_q, div_clk_d;
    logic             tick_q, tick_d;
    logic             wrap_s;
    logic             apply_s;
    logic [DIV_W:0]   half_s;

    // Next-state counter/ratio logic; outputs are decoded from the next state
    // so they leave the flops aligned with the counter.
    always_comb begin
        cnt_d     = cnt_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        apply_s   = 1'b0;
        wrap_s    = run_q && (cnt_q == (active_q - ONE));

        if (!en_i) begin
            // Disabled: park at 0; a pending ratio needs no boundary to wait for.
            cnt_d   = '0;
            apply_s = pending_q;
        end else if (!run_q || sync_i || wrap_s) begin
            // Start of a period: first enabled cycle, sync restart or natural wrap.
            cnt_d   = '0;
            apply_s = pending_q;
        end else begin
            cnt_d = cnt_q + ONE;
        end

        if (apply_s) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else begin
            active_d  = active_q;
        end

        // A write is only accepted while nothing is pending, so it never
        // collides with an apply in the same cycle.
        if (wr_i) begin
            shadow_d  = clamp_div(wr_div_i);
            pending_d = 1'b1;
        end else begin
            shadow_d  = shadow_q;
        end

        // ceil(N/2) computed one bit wider so N = 2^DIV_W-1 cannot overflow.
        half_s    = ({1'b0, active_d} + ONE_W) >> 1;
        div_clk_d = en_i && ({1'b0, cnt_d} < half_s);
        tick_d    = en_i && (cnt_d == (active_d - ONE));
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q     <= '0;
            active_q  <= DEF_N;
            shadow_q  <= DEF_N;
            pending_q <= 1'b0;
            run_q     <= 1'b0;
            div_clk_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            run_q     <= en_i;
            div_clk_q <= div_clk_d;
            tick_q    <= tick_d;
        end
    end

    assign div_clk_o = div_clk_q;
    assign tick_o    = tick_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel runtime-programmable clock divider.
//   clk_100MHz   system clock, all logic on the rising edge
//   reset        synchronous active-high reset
//   cfg_valid/cfg_ready/cfg_ch/cfg_div  ratio write port (valid/ready)
//   ch_en        per-channel run enable
//   sync         one-cycle pulse restarting every enabled channel at cnt = 0
//   div_clk      registered divided clocks
//   tick         registered one-cycle end-of-period pulses
//   cfg_pending  per-channel flag: shadow ratio not yet applied
module prog_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = clkdiv_pkg::DEFAULT_DIV
) (
    input  logic                          clk_100MHz,
    input  logic                          reset,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [ch_idx_w(NUM_CH)-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]              cfg_div,
    input  logic [NUM_CH-1:0]             ch_en,
    input  logic                          sync,
    output logic [NUM_CH-1:0]             div_clk,
    output logic [NUM_CH-1:0]             tick,
    output logic [NUM_CH-1:0]             cfg_pending
);

    logic [NUM_CH-1:0] pending_s;
    logic [NUM_CH-1:0] wr_s;
    logic              sel_pending_s;
    logic              cfg_ready_s;

    // Ready decode: an out-of-range channel reads as busy, so it is never written.
    always_comb begin
        sel_pending_s = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_pending_s = (int'(cfg_ch) == i) ? pending_s[i] : sel_pending_s;
        end
        cfg_ready_s = !reset && !sel_pending_s;
    end

    // Steer an accepted write to exactly one channel.
    always_comb begin
        wr_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_s[i] = cfg_valid && cfg_ready_s && (int'(cfg_ch) == i);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clkdiv_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk_i     (clk_100MHz),
            .reset_i   (reset),
            .en_i      (ch_en[g]),
            .sync_i    (sync),
            .wr_i      (wr_s[g]),
            .wr_div_i  (cfg_div),
            .div_clk_o (div_clk[g]),
            .tick_o    (tick[g]),
            .pending_o (pending_s[g])
        );
    end

    assign cfg_ready   = cfg_ready_s;
    assign cfg_pending = pending_s;

endmodule
